regs_wb_arbiter: RTL and testbench
==================================

// Module: regs_wb_arbiter
// PURPOSE
//   Write-back arbiter for the single write port of the general register file.
//   Shares the port between four requesters: ALU, LSU, MUL/DIV and JTAG debug.
//   Fixed priority with per-requester starvation promotion; one registered output stage.
//   Drives the regfile we/waddr/wdata inputs; JTAG writes no longer bypass arbitration.
// PARAMETERS
//   ADDR_W       5   register address width (matches REG_ADDR_WIDTH)
//   DATA_W       32  register data width (matches REG_DATA_WIDTH)
//   STARVE_LIMIT 8   wait cycles after which a requester is promoted to urgent (>=1)
// PORTS
//   clk          in   1              core clock
//   rst          in   1              reset, synchronous, active-high
//   req_valid_i  in   4              per-requester write request; [0]=ALU [1]=LSU [2]=MULDIV [3]=JTAG
//   req_addr_i   in   4*ADDR_W       packed dest addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data_i   in   4*DATA_W       packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o  out  4              one-hot grant; request accepted on valid&ready
//   we_o         out  1              regfile write enable
//   waddr_o      out  ADDR_W         regfile write address
//   wdata_o      out  DATA_W         regfile write data
//   urgent_o     out  4              requester i currently promoted (debug/perf)
// BEHAVIOUR
//   - One clock domain (clk); reset synchronous active-high, sampled on posedge clk.
//   - Reset: we_o=0, waddr_o=0, wdata_o=0, urgent_o=0, all wait counters 0; an
//     in-flight registered write is discarded (we_o low on cycle after rst).
//   - Handshake: requester holds valid, addr, data stable until ready seen high.
//     ready is combinational from valid + counters; never high without valid.
//     At most one ready bit high per cycle; exactly one if any valid is high.
//   - Grant order: urgent requesters first, lowest index among urgent wins;
//     otherwise lowest index among valid wins (ALU > LSU > MULDIV > JTAG).
//   - Wait counter i (width clog2(STARVE_LIMIT+1)): +1 each cycle valid_i & !ready_i,
//     saturates at STARVE_LIMIT; cleared when ready_i & valid_i, or when valid_i low.
//     urgent_o[i] = (counter_i == STARVE_LIMIT). Counter 0 exists but ALU only
//     starves if an urgent lower requester wins.
//   - Output stage: regfile always accepts, so stage drains every cycle; no backpressure.
//     Grant in cycle N -> we_o=1, waddr_o/wdata_o = winner payload in cycle N+1.
//     No grant in N -> we_o=0 in N+1; waddr_o/wdata_o hold last value.
//   - x0 writes: a request with addr==0 is granted and consumed normally but
//     produces we_o=0 in N+1 (waddr_o/wdata_o hold).
//   - Same-address writes in back-to-back cycles are not merged; both reach the
//     regfile in grant order (last write wins).
//   - Requester dropping valid without ready: legal only for JTAG; counter clears.
// TESTING
//   1 Reset: rst=1 with all valid=1 -> ready=0? no: ready follows valid; we_o=0 during
//     and one cycle after rst; counters 0 after release.
//   2 Single ALU write addr=5 data=0xDEADBEEF at cycle N -> ready_o=4'b0001 in N;
//     we_o=1 waddr_o=5 wdata_o=0xDEADBEEF in N+1; we_o=0 in N+2.
//   3 All four valid every cycle, STARVE_LIMIT=8: ALU granted cycles 0..7; LSU,MULDIV,
//     JTAG counters hit 8 at cycle 8; grants LSU (8), MULDIV (9), JTAG (10) in order.
//   4 JTAG write addr=0 data=0x1234 alone -> ready_o=4'b1000; we_o stays 0 next cycle.
//   5 LSU and MULDIV both write addr=10 (data 0x1,0x2) same cycle -> LSU in N+1,
//     MULDIV in N+2; final regfile x10 = 0x2.
//   6 rst asserted the cycle after a grant -> we_o=0 next cycle, write lost;
//     requester re-presents after reset and is granted with counter 0.

Source files
------------

// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter for the single regfile write port.
// Fixed priority with starvation promotion, one registered output stage.
module regs_wb_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req_valid_i,
    input  logic [4*ADDR_W-1:0] req_addr_i,
    input  logic [4*DATA_W-1:0] req_data_i,
    output logic [3:0]          req_ready_o,
    output logic                we_o,
    output logic [ADDR_W-1:0]   waddr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [3:0]          urgent_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  wait_cnt [4];
    logic [3:0]        urgent_req;
    logic [3:0]        pick;
    logic [3:0]        grant;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              wr_hit;
    logic              we_q;

    always_comb begin
        urgent_o = '0;
        for (int i = 0; i < 4; i++) begin
            urgent_o[i] = (wait_cnt[i] == CNT_MAX);
        end
    end

    // Urgent requesters pre-empt the fixed order; lowest set bit wins.
    assign urgent_req  = urgent_o & req_valid_i;
    assign pick        = (|urgent_req) ? urgent_req : req_valid_i;
    assign grant       = pick & (~pick + 4'd1);
    assign req_ready_o = grant;

    always_comb begin
        sel = 2'd0;
        unique case (1'b1)
            grant[0]: sel = 2'd0;
            grant[1]: sel = 2'd1;
            grant[2]: sel = 2'd2;
            grant[3]: sel = 2'd3;
            default:  sel = 2'd0;
        endcase
    end

    assign sel_addr = req_addr_i[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_data = req_data_i[int'(sel)*DATA_W +: DATA_W];
    assign wr_hit   = (|grant) && (sel_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid_i[i] || grant[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CNT_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    // x0 writes are consumed but never reach the regfile.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else begin
            we_q <= wr_hit;
            if (wr_hit) begin
                waddr_o <= sel_addr;
                wdata_o <= sel_data;
            end
        end
    end

    // An in-flight write is dropped if reset lands on its output cycle.
    assign we_o = we_q & ~rst;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Randomized bench for regs_wb_arbiter against a behavioural model.
// Directed scenarios first, then random traffic with random resets.
module tb_regs_wb_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    valid;
    logic [4*AW-1:0] addr_bus;
    logic [4*DW-1:0] data_bus;
    logic [3:0]    req_ready_o;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;
    logic [3:0]    urgent_o;

    logic [AW-1:0] r_addr [4];
    logic [DW-1:0] r_data [4];

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign addr_bus[g*AW +: AW] = r_addr[g];
        assign data_bus[g*DW +: DW] = r_data[g];
    end

    regs_wb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(valid),
        .req_addr_i(addr_bus),
        .req_data_i(data_bus),
        .req_ready_o(req_ready_o),
        .we_o(we_o),
        .waddr_o(waddr_o),
        .wdata_o(wdata_o),
        .urgent_o(urgent_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            m_wait [4];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    exp_g;
    logic [3:0]    obs_ready;
    logic [DW-1:0] rf [32];
    logic [3:0]    seq [11];
    bit            pend [4];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Urgent (waited LIM cycles) first, then plain fixed priority.
    function automatic logic [3:0] model_grant();
        logic [3:0] g = 4'b0;
        for (int i = 0; i < 4; i++)
            if (g == 0 && valid[i] && m_wait[i] == LIM) g = 4'(1 << i);
        for (int i = 0; i < 4; i++)
            if (g == 0 && valid[i]) g = 4'(1 << i);
        return g;
    endfunction

    task automatic step(input bit en);
        logic [3:0] eu;
        int         w;
        @(negedge clk);
        #1;
        exp_g     = model_grant();
        obs_ready = req_ready_o;
        eu = 4'b0;
        for (int i = 0; i < 4; i++) eu[i] = (m_wait[i] == LIM);
        if (en) begin
            check("ready", req_ready_o, exp_g);
            check("urgent", urgent_o, eu);
            check("we", we_o, m_we & !rst);
            check("waddr", waddr_o, m_waddr);
            check("wdata", wdata_o, m_wdata);
        end
        if (we_o === 1'b1) rf[waddr_o] = wdata_o;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_wait[i] = 0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_we = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (exp_g[i] && r_addr[i] != 0) begin
                    m_we = 1'b1; m_waddr = r_addr[i]; m_wdata = r_data[i];
                end
                w = m_wait[i] + 1;
                if (!valid[i] || exp_g[i]) m_wait[i] = 0;
                else m_wait[i] = (w > LIM) ? LIM : w;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid = 4'b0;
        for (int i = 0; i < 4; i++) begin
            r_addr[i] = '0; r_data[i] = '0; m_wait[i] = 0; pend[i] = 0;
        end
        for (int i = 0; i < 32; i++) rf[i] = '0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        step(0);

        // reset with every requester valid
        valid = 4'hF;
        step(1);
        check("t1_rdy", obs_ready, 4'b0001);
        rst = 1'b0; valid = 4'b0;
        #1;
        check("t1_we_after", we_o, 1'b0);
        check("t1_urg", urgent_o, 4'b0);
        step(1);

        // single ALU write
        valid = 4'b0001; r_addr[0] = 5; r_data[0] = 32'hDEADBEEF;
        step(1);
        check("t2_rdy", obs_ready, 4'b0001);
        check("t2_we", we_o, 1'b1);
        check("t2_waddr", waddr_o, 5);
        check("t2_wdata", wdata_o, 32'hDEADBEEF);
        valid = 4'b0;
        step(1);
        check("t2_we_off", we_o, 1'b0);

        // all four valid: starvation promotion
        for (int i = 0; i < 4; i++) begin
            r_addr[i] = AW'(i + 1); r_data[i] = 32'h100 + i;
        end
        valid = 4'hF;
        for (int c = 0; c < 11; c++) begin
            step(1);
            seq[c] = obs_ready;
        end
        for (int c = 0; c < 8; c++) check("t3_alu", seq[c], 4'b0001);
        check("t3_lsu", seq[8], 4'b0010);
        check("t3_mdv", seq[9], 4'b0100);
        check("t3_jtg", seq[10], 4'b1000);
        valid = 4'b0;
        step(1);

        // JTAG write to x0
        valid = 4'b1000; r_addr[3] = 0; r_data[3] = 32'h1234;
        step(1);
        check("t4_rdy", obs_ready, 4'b1000);
        check("t4_we", we_o, 1'b0);
        valid = 4'b0;
        step(1);

        // same-address writes, not merged
        rf[10] = '0;
        valid = 4'b0110;
        r_addr[1] = 10; r_data[1] = 32'h1;
        r_addr[2] = 10; r_data[2] = 32'h2;
        step(1);
        check("t5_rdy1", obs_ready, 4'b0010);
        check("t5_wd1", wdata_o, 32'h1);
        valid = 4'b0100;
        step(1);
        check("t5_rdy2", obs_ready, 4'b0100);
        check("t5_wd2", wdata_o, 32'h2);
        check("t5_we2", we_o, 1'b1);
        valid = 4'b0;
        step(1);
        check("t5_rf", rf[10], 32'h2);

        // reset right after a grant loses the write
        valid = 4'b0001; r_addr[0] = 7; r_data[0] = 32'hAA;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check("t6_we_lost", we_o, 1'b0);
        r_data[0] = 32'hBB;
        step(1);
        check("t6_rdy", obs_ready, 4'b0001);
        check("t6_we", we_o, 1'b1);
        check("t6_wdata", wdata_o, 32'hBB);
        valid = 4'b0;
        step(1);

        // random traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 3 && pend[3] && $urandom_range(0, 9) == 0) pend[3] = 0;
                else if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    r_addr[i] = ($urandom_range(0, 7) == 0) ? '0
                              : AW'($urandom_range(1, 31));
                    r_data[i] = $urandom;
                end
            end
            rst = ($urandom_range(0, 59) == 0);
            valid = {pend[3], pend[2], pend[1], pend[0]};
            step(1);
            for (int i = 0; i < 4; i++) if (exp_g[i]) pend[i] = 0;
        end
        rst = 1'b0; valid = 4'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
